// File: rtl/fifo_wr_arbiter_if.sv
// Requester/FIFO-side bundle for fifo_wr_arbiter: request words in, grant and FIFO write out.
interface fifo_wr_arbiter_if #(
  parameter int WIDTH   = 16,
  parameter int NUM_REQ = 4
);
  logic [NUM_REQ-1:0]       req;
  logic [NUM_REQ*WIDTH-1:0] req_data;
  logic                     full;
  logic [NUM_REQ-1:0]       gnt;
  logic                     fifo_wr_en;
  logic [WIDTH-1:0]         fifo_data;
  logic                     busy;

  modport master (
    output req, req_data, full,
    input  gnt, fifo_wr_en, fifo_data, busy
  );

  modport slave (
    input  req, req_data, full,
    output gnt, fifo_wr_en, fifo_data, busy
  );
endinterface

// File: rtl/fifo_wr_arbiter.sv
// Round-robin burst arbiter funnelling NUM_REQ requesters into one FIFO write port.
// state | meaning
// IDLE  | no owner; arbitrate among req starting at rr_ptr
// GRANT | owner holds the port for up to BURST_MAX beats
module fifo_wr_arbiter #(
  parameter int WIDTH     = 16,
  parameter int NUM_REQ   = 4,
  parameter int BURST_MAX = 4
) (
  input  logic               clk,
  input  logic               rst,
  fifo_wr_arbiter_if.slave   bus
);
  localparam int PW = $clog2(NUM_REQ);
  localparam int CW = $clog2(BURST_MAX) + 1;

  typedef enum logic {IDLE = 1'b0, GRANT = 1'b1} state_t;

  state_t             state_q, state_d;
  logic [NUM_REQ-1:0] gnt_q, gnt_d;
  logic [PW-1:0]      owner_q, owner_d;
  logic [PW-1:0]      rr_ptr_q, rr_ptr_d;
  logic [CW-1:0]      beat_cnt_q, beat_cnt_d;
  logic [PW-1:0]      pick;
  logic [PW-1:0]      owner_nxt;
  logic               wr_en;

  // Lowest offset from rr_ptr wins, so scan offsets from high to low.
  always_comb begin : rr_search
    int idx;
    pick = rr_ptr_q;
    idx  = 0;
    for (int k = NUM_REQ - 1; k >= 0; k--) begin
      idx = int'(rr_ptr_q) + k;
      if (idx >= NUM_REQ) idx = idx - NUM_REQ;
      if (bus.req[PW'(idx)]) pick = PW'(idx);
    end
  end

  assign owner_nxt = (owner_q == PW'(NUM_REQ - 1)) ? '0 : owner_q + 1'b1;

  // Reset cycle must not write even though the old owner is still registered.
  assign wr_en = (state_q == GRANT) && bus.req[owner_q] && !bus.full && !rst;

  always_comb begin
    bus.fifo_data = '0;
    if (gnt_q != '0) bus.fifo_data = bus.req_data[int'(owner_q)*WIDTH +: WIDTH];
  end

  assign bus.fifo_wr_en = wr_en;
  assign bus.gnt        = gnt_q;
  assign bus.busy       = (state_q == GRANT);

  always_comb begin
    state_d    = state_q;
    gnt_d      = gnt_q;
    owner_d    = owner_q;
    rr_ptr_d   = rr_ptr_q;
    beat_cnt_d = beat_cnt_q;
    case (state_q)
      IDLE: begin
        if (|bus.req) begin
          state_d     = GRANT;
          owner_d     = pick;
          gnt_d       = '0;
          gnt_d[pick] = 1'b1;
          beat_cnt_d  = '0;
        end
      end
      GRANT: begin
        if (wr_en) beat_cnt_d = beat_cnt_q + 1'b1;
        // Full with req held just stalls; only burst end or req drop releases.
        if ((wr_en && beat_cnt_q == CW'(BURST_MAX - 1)) || !bus.req[owner_q]) begin
          state_d  = IDLE;
          gnt_d    = '0;
          rr_ptr_d = owner_nxt;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= IDLE;
      gnt_q      <= '0;
      owner_q    <= '0;
      rr_ptr_q   <= '0;
      beat_cnt_q <= '0;
    end else begin
      state_q    <= state_d;
      gnt_q      <= gnt_d;
      owner_q    <= owner_d;
      rr_ptr_q   <= rr_ptr_d;
      beat_cnt_q <= beat_cnt_d;
    end
  end
endmodule

// File: tb/tb_fifo_wr_arbiter.sv
// Directed bench for fifo_wr_arbiter: requester word model, per-cycle expected grant/write/data.
module tb_fifo_wr_arbiter;
  logic clk;
  logic rst;
  int   checks;
  int   failures;
  int   cnt [4];

  fifo_wr_arbiter_if #(.WIDTH(16), .NUM_REQ(4)) bus ();

  fifo_wr_arbiter #(.WIDTH(16), .NUM_REQ(4), .BURST_MAX(4)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.slave)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  function automatic logic [15:0] word(input int i);
    logic [15:0] base;
    base = 16'h1000 * 16'(i + 1);
    return base + 16'(cnt[i]);
  endfunction

  task automatic load_data();
    for (int i = 0; i < 4; i++) bus.req_data[i*16 +: 16] = word(i);
  endtask

  task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // One cycle: inputs already applied at negedge; check, cross the edge, advance requester words.
  task automatic cyc(input logic [3:0] eg, input logic ew, input string tag);
    int          ow;
    logic [15:0] ed;
    #1;
    ow = -1;
    for (int i = 0; i < 4; i++) if (eg[i]) ow = i;
    ed = (ow >= 0) ? word(ow) : 16'h0;
    chk({tag, ".gnt"},  16'(bus.gnt), 16'(eg));
    chk({tag, ".wr"},   16'(bus.fifo_wr_en), 16'(ew));
    chk({tag, ".busy"}, 16'(bus.busy), 16'(|eg));
    chk({tag, ".data"}, bus.fifo_data, ed);
    chk({tag, ".onehot0"}, 16'($onehot0(bus.gnt)), 16'd1);
    chk({tag, ".wr_safe"}, 16'(!bus.fifo_wr_en || (!bus.full && bus.busy)), 16'd1);
    @(posedge clk);
    if (ew && ow >= 0) cnt[ow] = cnt[ow] + 1;
    load_data();
    @(negedge clk);
  endtask

  initial begin
    checks   = 0;
    failures = 0;
    for (int i = 0; i < 4; i++) cnt[i] = 0;
    rst      = 1'b1;
    bus.req  = 4'b0000;
    bus.full = 1'b0;
    load_data();
    @(negedge clk);
    cyc(4'b0000, 1'b0, "reset");
    rst = 1'b0;

    // Single requester: 4 beats, bubble, regrant, then drop.
    bus.req = 4'b0010;
    cyc(4'b0000, 1'b0, "t1_arb");
    for (int b = 0; b < 4; b++) cyc(4'b0010, 1'b1, $sformatf("t1_beat%0d", b + 1));
    cyc(4'b0000, 1'b0, "t1_bubble");
    cyc(4'b0010, 1'b1, "t1_regrant");
    bus.req = 4'b0000;
    cyc(4'b0010, 1'b0, "t1_drop");
    cyc(4'b0000, 1'b0, "t1_idle");

    // All requesting from reset: order 0,1,2,3,0.
    rst = 1'b1;
    @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    bus.req = 4'b1111;
    cyc(4'b0000, 1'b0, "t2_arb");
    for (int k = 0; k < 5; k++) begin
      for (int b = 0; b < 4; b++)
        cyc(4'(1 << (k % 4)), 1'b1, $sformatf("t2_g%0d_beat%0d", k, b + 1));
      if (k == 4) bus.req = 4'b0000;
      cyc(4'b0000, 1'b0, $sformatf("t2_bubble%0d", k));
    end

    // Owner 1 stalled by full for 5 cycles after beat 2.
    bus.req = 4'b0010;
    cyc(4'b0000, 1'b0, "t3_arb");
    cyc(4'b0010, 1'b1, "t3_beat1");
    cyc(4'b0010, 1'b1, "t3_beat2");
    bus.full = 1'b1;
    for (int s = 0; s < 5; s++) cyc(4'b0010, 1'b0, $sformatf("t3_full%0d", s));
    bus.full = 1'b0;
    cyc(4'b0010, 1'b1, "t3_beat3");
    cyc(4'b0010, 1'b1, "t3_beat4");
    bus.req = 4'b0000;
    cyc(4'b0000, 1'b0, "t3_bubble");

    // Owner 2 drops after one beat; requester 3 is next.
    bus.req = 4'b0100;
    cyc(4'b0000, 1'b0, "t4_arb");
    cyc(4'b0100, 1'b1, "t4_beat1");
    bus.req = 4'b1000;
    cyc(4'b0100, 1'b0, "t4_drop");
    cyc(4'b0000, 1'b0, "t4_bubble");
    cyc(4'b1000, 1'b1, "t5_beat1");

    // Reset during owner 3 beat 2: no write, then requester 0 first.
    rst = 1'b1;
    cyc(4'b1000, 1'b0, "t5_rst_cycle");
    rst = 1'b0;
    bus.req = 4'b1001;
    cyc(4'b0000, 1'b0, "t5_post_rst");
    cyc(4'b0001, 1'b1, "t5_grant0");
    bus.req = 4'b0000;
    cyc(4'b0001, 1'b0, "t5_drop");
    cyc(4'b0000, 1'b0, "t5_idle");

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/fifo_wr_arbiter.md
FIFO_WR_ARBITER -- requirements
Module: fifo_wr_arbiter

Interface
REQ-001 SHALL have parameter WIDTH, default 16: data word width, matching the FIFO data_in width.
REQ-002 SHALL have parameter NUM_REQ, default 4: number of requesters (2..8).
REQ-003 SHALL have parameter BURST_MAX, default 4: maximum words per grant (1..16).
REQ-004 SHALL have port clk  input  1: single clock, the FIFO write clock; all logic on rising edge.
REQ-005 SHALL have port rst  input  1: reset, synchronous, active-high.
REQ-006 SHALL have port req  input  NUM_REQ: bit i = requester i has a word ready.
REQ-007 SHALL have port req_data  input  NUM_REQ*WIDTH: slice [i*WIDTH +: WIDTH] = requester i word.
REQ-008 SHALL have port full  input  1: FIFO full flag, write domain.
REQ-009 SHALL have port gnt  output  NUM_REQ: registered one-hot grant; all-zero when no owner.
REQ-010 SHALL have port fifo_wr_en  output  1: FIFO write enable.
REQ-011 SHALL have port fifo_data  output  WIDTH: FIFO data_in.
REQ-012 SHALL have port busy  output  1: high while in GRANT state.

Function
REQ-013 SHALL implement two states, IDLE and GRANT, plus a round-robin pointer rr_ptr and a beat counter beat_cnt ($clog2(BURST_MAX)+1 bits).
REQ-014 In IDLE with req != 0, SHALL select the first requester with req high, searching rr_ptr, rr_ptr+1, ... modulo NUM_REQ.
REQ-015 On that selection, SHALL register gnt = one-hot(owner), clear beat_cnt, and enter GRANT on the next edge.
REQ-016 In IDLE with req == 0, SHALL stay in IDLE with gnt = 0.
REQ-017 In GRANT, SHALL assert fifo_wr_en combinationally = req[owner] && !full.
REQ-018 fifo_data SHALL equal the owner's req_data slice; it SHALL be 0 when gnt == 0.
REQ-019 A transfer (beat) SHALL occur in any cycle with fifo_wr_en high; each beat SHALL increment beat_cnt.
REQ-020 On the beat that makes beat_cnt == BURST_MAX, SHALL release the grant.
REQ-021 On any GRANT cycle with req[owner] low, SHALL release the grant, with no write in that cycle.
REQ-022 A release SHALL take effect at the edge: gnt -> 0, state -> IDLE, rr_ptr -> (owner+1) mod NUM_REQ.
REQ-023 Each grant SHALL therefore be followed by one IDLE arbitration bubble cycle.
REQ-024 While full is high and req[owner] is high, SHALL hold the grant: no beat, no beat_cnt change, no timeout.
REQ-025 fifo_wr_en SHALL never assert while full is high or while state is IDLE.
REQ-026 With every requester continuously asserting, each SHALL receive a grant within NUM_REQ arbitration rounds (starvation-free).
REQ-027 Requester i SHALL treat (gnt[i] && req[i] && !full) as word accepted and SHALL advance its req_data on the next edge.

Reset
REQ-028 On rst high at a clock edge, SHALL set state = IDLE, gnt = 0, rr_ptr = 0, beat_cnt = 0; the next cycle SHALL show fifo_wr_en = 0, fifo_data = 0, busy = 0.
REQ-029 Reset mid-burst SHALL abort the burst without writing in the reset cycle; the first grant after reset SHALL follow REQ-014 with rr_ptr = 0.
REQ-030 Reset SHALL take priority over every other transition.

Verification
REQ-031 SHALL cover: single requester, req = 4'b0010 held, full = 0 -> gnt = 4'b0010 one cycle after request; 4 consecutive writes; one IDLE bubble; regrant; rr_ptr = 2 after first release.
REQ-032 SHALL cover: all req = 4'b1111 held, from reset -> grant order 0, 1, 2, 3, 0; each grant exactly 4 beats; fifo_data matches the owner slice on every beat.
REQ-033 SHALL cover: owner 1 granted, full high for 5 cycles after beat 2 -> fifo_wr_en = 0 for those 5 cycles; grant held; beats 3-4 after full drops; total 4 beats.
REQ-034 SHALL cover: owner 2 drops req after beat 1 -> release next edge; 1 word written; rr_ptr = 3; requester 3 is granted next if requesting.
REQ-035 SHALL cover: rst pulsed during beat 2 of owner 3 -> gnt = 0 and fifo_wr_en = 0 next cycle; with req = 4'b1001 afterwards, requester 0 is granted first.
REQ-036 SHALL check by assertion throughout: gnt one-hot or zero; fifo_wr_en implies !full && busy.
